// File: rtl/mux_pkg.sv
// Shared types and default sizing for the N:1 round-robin channel merger
// and the arbiter that drives it.
package mux_pkg;

  typedef enum logic [1:0] {
    MODE_FORCED   = 2'b00,
    MODE_PRIORITY = 2'b01,
    MODE_RR       = 2'b10,
    MODE_RSVD     = 2'b11
  } mux_mode_e;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_mux_nto1_arbiter.sv
// Grant logic for the channel merger: forced, fixed-priority or round-robin
// selection over the request vector, plus the round-robin pointer it owns.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  force_sel,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  mux_mode_e        mode_e;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_ptr_d;
  logic             found;
  int               rr_idx;

  assign mode_e = mux_mode_e'(mode);

  // Forced indices past NUM_CH never match a loop index, so they grant nothing.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    rr_idx    = 0;
    case (mode_e)
      MODE_FORCED: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (force_sel == SEL_W'(i) && req[i]) begin
            grant[i]  = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
      MODE_PRIORITY: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && req[i]) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          rr_idx = int'(rr_ptr_q) + k;
          if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
          if (!found && req[rr_idx]) begin
            found          = 1'b1;
            grant[rr_idx]  = 1'b1;
            grant_idx      = SEL_W'(rr_idx);
          end
        end
      end
    endcase
  end

  // Wrap explicitly so non-power-of-2 channel counts never walk past NUM_CH-1.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && (mode_e == MODE_RR || mode_e == MODE_RSVD)) begin
      if (int'(grant_idx) == NUM_CH - 1) rr_ptr_d = '0;
      else                                rr_ptr_d = grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/rr_mux_nto1.sv
// N:1 handshaked channel merger: arbitrates among valid inputs and captures
// the winning beat into a one-entry output register.
module rr_mux_nto1
  import mux_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         force_sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load_en;
  logic              transfer;
  logic [DATA_W-1:0] sel_data;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .mode      (mode),
    .force_sel (force_sel),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The register can refill in the same cycle its held beat is consumed.
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = grant & {NUM_CH{load_en}};
  assign transfer = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_nto1.sv
// Directed bench for rr_mux_nto1: an 8-channel instance for the main scenarios
// and a 6-channel instance for out-of-range forced select and modulo wrap.
module tb_rr_mux_nto1;

  logic        clk;
  logic        rst;

  logic [1:0]  mode;
  logic [2:0]  force_sel;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_ready;

  logic [1:0]  mode6;
  logic [2:0]  force_sel6;
  logic [5:0]  in_valid6;
  logic [47:0] in_data6;
  logic [5:0]  in_ready6;
  logic        out_valid6;
  logic [7:0]  out_data6;
  logic [2:0]  out_sel6;
  logic        out_ready6;

  int checks;
  int errors;

  rr_mux_nto1 #(.NUM_CH(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .force_sel(force_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_mux_nto1 #(.NUM_CH(6), .DATA_W(8)) dut6 (
    .clk(clk), .rst(rst), .mode(mode6), .force_sel(force_sel6),
    .in_valid(in_valid6), .in_data(in_data6), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_data(out_data6), .out_sel(out_sel6),
    .out_ready(out_ready6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 2'b00; force_sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    mode6 = 2'b00; force_sel6 = '0; in_valid6 = '0; in_data6 = '0; out_ready6 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 8'h00 || out_data !== 8'h00 || out_sel !== 3'd0) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc %0d: got v=%b rdy=%h d=%h s=%0d expected v=0 rdy=00 d=00 s=0",
                 c, out_valid, in_ready, out_data, out_sel);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_d [3];
    logic [2:0] exp_s [3];
    logic [7:0] vseq  [3];
    exp_d = '{8'hA2, 8'hA3, 8'hA5};
    exp_s = '{3'd2, 3'd3, 3'd5};
    vseq  = '{8'b0010_1100, 8'b0010_1000, 8'b0010_0000};
    mode = 2'b01;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);
    for (int b = 0; b < 3; b++) begin
      in_valid = vseq[b];
      #1;
      checks++;
      if (in_ready !== (8'h01 << exp_s[b])) begin
        errors++;
        $display("[TB] FAIL prio_ready beat %0d: got %b expected %b", b, in_ready, 8'h01 << exp_s[b]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[b] || out_sel !== exp_s[b]) begin
        errors++;
        $display("[TB] FAIL prio_beat %0d: got v=%b d=%h s=%0d expected v=1 d=%h s=%0d",
                 b, out_valid, out_data, out_sel, exp_d[b], exp_s[b]);
      end
    end
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL prio_drain: got v=%b d=%h expected v=0 d=a5", out_valid, out_data);
    end
  endtask

  // Priority mode leaves the round-robin pointer at its reset value of 0.
  task automatic test_rr_all();
    mode = 2'b10;
    out_ready = 1'b1;
    in_valid = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (in_ready !== 8'(8'h01 << (k % 8))) begin
        errors++;
        $display("[TB] FAIL rr_ready step %0d: got %b expected %b", k, in_ready, 8'(8'h01 << (k % 8)));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== 8'(8'hA0 + (k % 8))) begin
        errors++;
        $display("[TB] FAIL rr_seq step %0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 k, out_valid, out_sel, out_data, k % 8, 8'(8'hA0 + (k % 8)));
      end
    end
    in_valid = '0;
    tick();
  endtask

  // Pointer sits at 2 here; ch3 is the only requester.
  task automatic test_back_pressure();
    mode = 2'b10;
    out_ready = 1'b0;
    in_data[3*8 +: 8] = 8'h33;
    in_valid = 8'h08;
    #1;
    checks++;
    if (in_ready !== 8'h08) begin
      errors++;
      $display("[TB] FAIL bp_first_ready: got %b expected 00001000", in_ready);
    end
    tick();
    in_data[3*8 +: 8] = 8'h34;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_data !== 8'h33 || out_sel !== 3'd3) begin
        errors++;
        $display("[TB] FAIL bp_stall cyc %0d: got rdy=%b v=%b d=%h s=%0d expected rdy=0 v=1 d=33 s=3",
                 c, in_ready, out_valid, out_data, out_sel);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h08) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b expected 00001000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h34 || out_sel !== 3'd3) begin
      errors++;
      $display("[TB] FAIL bp_second_beat: got v=%b d=%h s=%0d expected v=1 d=34 s=3",
               out_valid, out_data, out_sel);
    end
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_forced();
    mode = 2'b00;
    out_ready = 1'b1;
    force_sel = 3'd5;
    in_data[5*8 +: 8] = 8'h55;
    in_data[0 +: 8]   = 8'h11;
    in_valid = 8'h21;
    #1;
    checks++;
    if (in_ready !== 8'h20) begin
      errors++;
      $display("[TB] FAIL forced_ready: got %b expected 00100000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h55 || out_sel !== 3'd5) begin
      errors++;
      $display("[TB] FAIL forced_beat: got v=%b d=%h s=%0d expected v=1 d=55 s=5",
               out_valid, out_data, out_sel);
    end
    force_sel = 3'd2;
    #1;
    checks++;
    if (in_ready !== 8'h00) begin
      errors++;
      $display("[TB] FAIL forced_idle_sel: got %b expected 00000000", in_ready);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_six_channel();
    for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'(8'hB0 + i);
    mode6 = 2'b00;
    out_ready6 = 1'b1;
    force_sel6 = 3'd7;
    in_valid6 = 6'h3F;
    #1;
    checks++;
    if (in_ready6 !== 6'h00) begin
      errors++;
      $display("[TB] FAIL six_forced_oob_ready: got %b expected 000000", in_ready6);
    end
    tick();
    checks++;
    if (out_valid6 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL six_forced_oob_valid: got %b expected 0", out_valid6);
    end
    force_sel6 = 3'd4;
    tick();
    checks++;
    if (out_valid6 !== 1'b1 || out_sel6 !== 3'd4 || out_data6 !== 8'hB4) begin
      errors++;
      $display("[TB] FAIL six_forced_4: got v=%b s=%0d d=%h expected v=1 s=4 d=b4",
               out_valid6, out_sel6, out_data6);
    end
    mode6 = 2'b11;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (out_valid6 !== 1'b1 || out_sel6 !== 3'(k % 6) || out_data6 !== 8'(8'hB0 + (k % 6))) begin
        errors++;
        $display("[TB] FAIL six_rr_wrap step %0d: got s=%0d d=%h expected s=%0d d=%h",
                 k, out_sel6, out_data6, k % 6, 8'(8'hB0 + (k % 6)));
      end
    end
    in_valid6 = '0;
    tick();
  endtask

  // Pointer sits at 4 here; ch6 wins and then the beat stalls.
  task automatic test_reset_mid_stall();
    mode = 2'b10;
    out_ready = 1'b0;
    in_data[6*8 +: 8] = 8'h66;
    in_valid = 8'h40;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 3'd6 || out_data !== 8'h66) begin
      errors++;
      $display("[TB] FAIL rst_mid_setup: got v=%b s=%0d d=%h expected v=1 s=6 d=66",
               out_valid, out_sel, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: got v=%b d=%h s=%0d expected v=0 d=00 s=0",
               out_valid, out_data, out_sel);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'(k)) begin
        errors++;
        $display("[TB] FAIL rst_mid_restart step %0d: got v=%b s=%0d expected v=1 s=%0d",
                 k, out_valid, out_sel, k);
      end
    end
    in_valid = '0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_priority();
    test_rr_all();
    test_back_pressure();
    test_forced();
    test_six_channel();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_nto1.md
Name: rr_mux_nto1

Overview:
- Parametrised N:1 data selector. It generalises the combinational 8:1 mux into a registered, handshaked channel merger.
- Each input channel has valid/ready. One output channel is selected per cycle by mode: forced select, fixed priority, or round-robin.
- A one-entry output register decouples output backpressure from the inputs.
- Sits between multiple producers and a single consumer in the example datapaths, and is the basis for the next mux/arbiter benches.

Parameters:
- NUM_CH, 8, number of input channels, 2..32, need not be a power of 2.
- DATA_W, 8, width of each channel's data.
- SEL_W, $clog2(NUM_CH), width of select/index fields; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- mode  in  2  arbitration mode: 00 FORCED, 01 PRIORITY, 10 RR, 11 reserved (behaves as RR).
- force_sel  in  SEL_W  channel index used in FORCED mode.
- in_valid  in  NUM_CH  per-channel valid.
- in_data  in  NUM_CH*DATA_W  packed data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel ready; combinational.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered data.
- out_sel  out  SEL_W  index of the channel that produced the held beat.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
- load_en = !out_valid || out_ready. The output register may load in the same cycle the held beat leaves, giving full throughput of 1 beat/cycle.
- Grant: at most one-hot over in_valid, computed combinationally per mode.
  - FORCED: grant[force_sel] = in_valid[force_sel]. If force_sel >= NUM_CH, no grant.
  - PRIORITY: the lowest index with in_valid=1 wins.
  - RR: search starts at rr_ptr, wraps modulo NUM_CH; the first valid channel wins.
- in_ready[i] = grant[i] && load_en. Transfer on channel i = in_valid[i] && in_ready[i]. No channel sees in_ready=1 unless it is granted.
- On transfer from channel g:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_CH, updated only in RR/reserved modes.
- out_ready && out_valid with no transfer: out_valid <= 0 next cycle. out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_data and out_sel are stable; all in_ready=0.
- Latency: input transfer in cycle t gives out_valid=1 with that data in cycle t+1.
- Mode or force_sel changes take effect in the same cycle's arbitration. rr_ptr is retained across mode changes and is not reset.
- Wrap-around: a grant to NUM_CH-1 sets rr_ptr=0.
- Non-power-of-2 NUM_CH: pointer arithmetic is modulo NUM_CH, never SEL_W overflow.
- Reset mid-operation: the held beat is discarded, out_valid=0 immediately, rr_ptr returns to 0.
- Inputs are not required to hold valid when not ready. The block takes no action on withdrawn requests.

Decomposition:
- Package mux_pkg:
  - typedef enum logic [1:0] mux_mode_e {MODE_FORCED, MODE_PRIORITY, MODE_RR, MODE_RSVD}.
  - Default parameter constants.
- Sub-module rr_arbiter (NUM_CH):
  - inputs: req, mode, force_sel, advance.
  - outputs: one-hot grant, grant_idx.
  - owns rr_ptr and resets it.
- rr_mux_nto1 instantiates rr_arbiter, the data select, and the output register.

Test Plan:
- Reset then idle: all in_valid=0 -> out_valid=0, in_ready=0, out_data=0 for 10 cycles.
- PRIORITY, in_valid=8'b0010_1100, out_ready=1, data ch i = 8'hA0+i.
  - Beats are A2, A3, A5 on consecutive cycles, each with out_sel matching.
  - in_valid is dropped after each channel's handshake.
- RR, all 8 channels valid continuously, out_ready=1 -> out_sel sequence 0,1,...,7,0,1 with one beat every cycle.
- Backpressure: RR, ch3 valid, out_ready=0 for 4 cycles after the first beat.
  - out_data is held stable and in_ready=0 throughout.
  - With out_ready=1, the second ch3 beat loads the same cycle the first leaves.
- FORCED:
  - force_sel=5, ch5 valid with 8'h55, ch0 also valid -> only ch5 granted, out_data=8'h55.
  - NUM_CH=6 build, force_sel=7 -> no grant.
- Reset mid-stall: out_valid=1 held, assert rst for 1 cycle -> out_valid=0 immediately.
  - After release, RR restarts from ch0.
